led_pwm_ctrl: RTL and testbench
===============================

// Module: led_pwm_ctrl
// PURPOSE
//  Consumer of the SPI slave's decoded frame (cmd/addr/payload + frame-valid level). Executes
//  WRITE (set LED brightness 0..100 %) and READ (return stored brightness to the SPI TX path).
//  Drives NUM_LEDS PWM outputs to the board LEDs; all logic runs in the sysclk (125 MHz) domain.
// PARAMETERS
//  NUM_LEDS  4     LED channels; addressed 0..NUM_LEDS-1, needs NUM_LEDS <= 2**`ADDR_BITS
//  PRESCALE  1250  sysclk cycles per PWM step; PWM period = 100 steps (1 kHz @125 MHz)
// PORTS
//  sysclk     in   1              system clock, 125 MHz
//  rst_n      in   1              asynchronous, active-low reset
//  i_frame_dv in   1              frame-valid LEVEL from SPI slave (high from DONE until cs release)
//  i_cmd      in   `CMD_BITS      decoded command
//  i_addr     in   `ADDR_BITS     LED index
//  i_payload  in   `PAYLOAD_BITS  brightness in percent (WRITE); ignored for READ/NOP
//  i_rd_ack   in   1              TX path has taken o_rd_data
//  o_rd_valid out  1              read response pending
//  o_rd_data  out  `PAYLOAD_BITS  stored brightness of addressed LED
//  o_err      out  1              one-cycle pulse: bad addr or unknown cmd
//  o_led      out  NUM_LEDS       PWM outputs, bit i = LED i, active high
// BEHAVIOUR
//  Clock/reset: one clock, sysclk; rst_n asynchronous, active-low. Reset: all duty/shadow regs=0,
//   counters=0, o_led=0, o_rd_valid=0, o_rd_data=0, o_err=0, FSM=IDLE.
//  Frame accept: rising edge of i_frame_dv (registered previous value); a held level is ONE frame.
//   cmd/addr/payload sampled on that edge cycle into a command register.
//  FSM: IDLE -> EXEC on accept edge. EXEC (1 cycle) decodes:
//   CMD_WRITE, addr valid -> duty[addr] <= min(payload,100); -> IDLE
//   CMD_READ,  addr valid -> o_rd_data <= duty[addr], o_rd_valid <= 1; -> RESP
//   CMD_NOP -> IDLE, no side effect
//   addr >= NUM_LEDS or unknown cmd -> o_err pulse 1 cycle, no reg change; -> IDLE
//   RESP: hold o_rd_valid/o_rd_data stable until i_rd_ack=1, then clear o_rd_valid -> IDLE.
//  Latency: edge cycle +1 -> EXEC; duty write / o_rd_valid visible 2 cycles after i_frame_dv rises.
//  New accept edge while in RESP: response abandoned (o_rd_valid cleared), new frame executes.
//  i_rd_ack while o_rd_valid=0: ignored.
//  PWM: shared prescaler 0..PRESCALE-1; on wrap, step counter 0..99 advances (99 wraps to 0).
//   LED i on iff step < shadow[i]. shadow[i] <= duty[i] only when step wraps to 0 -> no glitch.
//   Duty 0: LED constantly low; duty 100: constantly high (no 1-step dip).
//  Payload > 100 saturates to 100 (stored and read back as 100).
//  rst_n asserted mid-frame or mid-RESP: immediate return to reset values, pending response lost.
// STRUCTURE
//  params.vh: `CMD_BITS=2, `ADDR_BITS=2, `PAYLOAD_BITS=7, `CMD_NOP=2'b00, `CMD_WRITE=2'b01,
//   `CMD_READ=2'b10, `PWM_STEPS=100, `ADDR_NONE; shared with spi_slave (no local copies).
//  Sub-module pwm_channel (one instance per LED, generate loop): inputs sysclk, rst_n, step,
//   period_start, duty; owns shadow reg and output flop. Prescaler/step counter and command
//   FSM stay in led_pwm_ctrl.
// TESTING (PRESCALE=2 in bench for speed)
//  1 Reset: rst_n low -> o_led=0, o_rd_valid=0, o_err=0; release, no frame -> outputs stay 0.
//  2 WRITE addr=1 payload=25 -> after next period start, o_led[1] high 25 of 100 steps, others 0.
//  3 WRITE addr=2 payload=127 then READ addr=2 -> o_rd_data=100, o_rd_valid held until i_rd_ack,
//    clears the cycle after ack.
//  4 i_frame_dv held high 50 cycles for one WRITE -> exactly one execution; READ addr=3 (4 LEDs)
//    with NUM_LEDS=3 -> single o_err pulse, no o_rd_valid.
//  5 Change duty 0->100 mid-period on LED0 -> o_led[0] stays 0 until step 0, then constantly 1,
//    no glitch; duty 100->0 gives constant 0 from next period.
//  6 Assert rst_n during RESP -> o_rd_valid=0 asynchronously, all duties 0, LEDs off.

Source files
------------

// File: rtl/led_pwm_ctrl_pkg.sv
// Shared types and constants for the LED PWM controller: command encodings,
// field widths, FSM state encoding and the captured-frame record.
package led_pwm_ctrl_pkg;

  localparam int CMD_BITS     = 2;
  localparam int ADDR_BITS    = 2;
  localparam int PAYLOAD_BITS = 7;
  localparam int PWM_STEPS    = 100;
  localparam int STEP_BITS    = 7;

  localparam logic [CMD_BITS-1:0] CMD_NOP   = 2'b00;
  localparam logic [CMD_BITS-1:0] CMD_WRITE = 2'b01;
  localparam logic [CMD_BITS-1:0] CMD_READ  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // One decoded SPI frame as captured on the accept edge.
  typedef struct packed {
    logic [CMD_BITS-1:0]     cmd;
    logic [ADDR_BITS-1:0]    addr;
    logic [PAYLOAD_BITS-1:0] payload;
  } frame_t;

  // Brightness is a percentage; anything above 100 is clamped to full on.
  function automatic logic [PAYLOAD_BITS-1:0] sat_pct(input logic [PAYLOAD_BITS-1:0] p);
    return (p > PAYLOAD_BITS'(PWM_STEPS)) ? PAYLOAD_BITS'(PWM_STEPS) : p;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_pwm_channel.sv
// One PWM output. The duty value is copied into a shadow register only at the
// start of a PWM period, so a brightness change never produces a short or
// split pulse inside the running period.
module led_pwm_ctrl_pwm_channel
  import led_pwm_ctrl_pkg::*;
(
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic [STEP_BITS-1:0]    step,
  input  logic                    period_start,
  input  logic [PAYLOAD_BITS-1:0] duty,
  output logic                    o_led
);

  logic [PAYLOAD_BITS-1:0] shadow_q, shadow_d;
  logic                    led_q, led_d;

  // Next shadow duty and next LED level; step is at most 99, so a duty of 100
  // keeps the LED on for the whole period and a duty of 0 keeps it off.
  always_comb begin
    shadow_d = period_start ? duty : shadow_q;
    led_d    = (step < shadow_q);
  end

  // Shadow and output registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      led_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      led_q    <= led_d;
    end
  end

  assign o_led = led_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED brightness controller fed by decoded SPI frames. Executes WRITE/READ
// commands against per-LED duty registers and drives one PWM output per LED.
//
// Read response handshake: o_rd_valid rises with o_rd_data; both stay stable
// until a cycle in which i_rd_ack=1 is sampled, after which o_rd_valid is low
// on the next cycle. i_rd_ack with o_rd_valid low has no effect. A new frame
// arriving while a response is pending drops that response.
module led_pwm_ctrl
  import led_pwm_ctrl_pkg::*;
#(
  parameter int NUM_LEDS = 4,
  parameter int PRESCALE = 1250
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    i_frame_dv,
  input  logic [CMD_BITS-1:0]     i_cmd,
  input  logic [ADDR_BITS-1:0]    i_addr,
  input  logic [PAYLOAD_BITS-1:0] i_payload,
  input  logic                    i_rd_ack,
  output logic                    o_rd_valid,
  output logic [PAYLOAD_BITS-1:0] o_rd_data,
  output logic                    o_err,
  output logic [NUM_LEDS-1:0]     o_led,
  output state_e                  o_dbg_state
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // ---------------- PWM timebase ----------------
  logic [PRESC_W-1:0]   presc_q, presc_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 step_tick;
  logic                 period_start;

  // Prescaler counts sysclk cycles per step; the step counter walks 0..99.
  always_comb begin
    step_tick    = (presc_q == PRESC_W'(PRESCALE - 1));
    period_start = step_tick && (step_q == STEP_BITS'(PWM_STEPS - 1));
    presc_d      = step_tick ? '0 : presc_q + 1'b1;
    step_d       = step_q;
    if (step_tick) begin
      step_d = period_start ? '0 : step_q + 1'b1;
    end
  end

  // Timebase registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      step_q  <= '0;
    end else begin
      presc_q <= presc_d;
      step_q  <= step_d;
    end
  end

  // ---------------- Command FSM ----------------
  state_e                  state_q, state_d;
  frame_t                  frame_q, frame_d;
  frame_t                  frame_in;
  logic                    dv_prev_q;
  logic                    accept;
  logic                    addr_ok;
  logic                    rd_valid_q, rd_valid_d;
  logic [PAYLOAD_BITS-1:0] rd_data_q, rd_data_d;
  logic                    err_q, err_d;
  logic [PAYLOAD_BITS-1:0] rd_sel;
  logic [PAYLOAD_BITS-1:0] duty_q [NUM_LEDS];
  logic [PAYLOAD_BITS-1:0] duty_d [NUM_LEDS];

  assign frame_in = '{cmd: i_cmd, addr: i_addr, payload: i_payload};
  // A frame-valid level held high counts once: only its rising edge accepts.
  assign accept   = i_frame_dv && !dv_prev_q;
  assign addr_ok  = (int'(frame_q.addr) < NUM_LEDS);

  // Duty of the addressed LED; a compare loop keeps out-of-range addresses
  // from indexing past the register array.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (frame_q.addr == ADDR_BITS'(i)) rd_sel = duty_q[i];
    end
  end

  // Next-state and command execution. An edge that lands during the single
  // EXEC cycle is not taken; SPI frames are far longer than that.
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    err_d      = 1'b0;
    duty_d     = duty_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_d = frame_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (frame_q.cmd)
          CMD_WRITE: begin
            if (addr_ok) begin
              for (int i = 0; i < NUM_LEDS; i++) begin
                if (frame_q.addr == ADDR_BITS'(i)) duty_d[i] = sat_pct(frame_q.payload);
              end
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_READ: begin
            if (addr_ok) begin
              rd_data_d  = rd_sel;
              rd_valid_d = 1'b1;
              state_d    = ST_RESP;
            end else begin
              err_d = 1'b1;
            end
          end
          CMD_NOP: ;
          default: err_d = 1'b1;
        endcase
      end
      ST_RESP: begin
        if (accept) begin
          rd_valid_d = 1'b0;
          frame_d    = frame_in;
          state_d    = ST_EXEC;
        end else if (i_rd_ack) begin
          rd_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, command, response and duty registers.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      dv_prev_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      dv_prev_q  <= i_frame_dv;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_LEDS; i++) duty_q[i] <= duty_d[i];
    end
  end

  assign o_rd_valid  = rd_valid_q;
  assign o_rd_data   = rd_data_q;
  assign o_err       = err_q;
  assign o_dbg_state = state_q;

  // ---------------- PWM channels ----------------
  logic [NUM_LEDS-1:0] led_w;

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
    led_pwm_ctrl_pwm_channel u_ch (
      .sysclk       (sysclk),
      .rst_n        (rst_n),
      .step         (step_q),
      .period_start (period_start),
      .duty         (duty_q[g]),
      .o_led        (led_w[g])
    );
  end

  assign o_led = led_w;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Bench for led_pwm_ctrl: randomized frames against a duty-table model,
// read/error events checked by a queue-based monitor, PWM checked by counting
// on-time over whole periods.
module tb_led_pwm_ctrl;
  import led_pwm_ctrl_pkg::*;

  localparam int NUM_LEDS = 3;
  localparam int PRESCALE = 2;
  localparam int PERIOD   = PWM_STEPS * PRESCALE;

  // ---------------- clock / reset / DUT ----------------
  logic                    sysclk = 1'b0;
  logic                    rst_n  = 1'b0;
  logic                    i_frame_dv = 1'b0;
  logic [CMD_BITS-1:0]     i_cmd = '0;
  logic [ADDR_BITS-1:0]    i_addr = '0;
  logic [PAYLOAD_BITS-1:0] i_payload = '0;
  logic                    i_rd_ack = 1'b0;
  logic                    o_rd_valid;
  logic [PAYLOAD_BITS-1:0] o_rd_data;
  logic                    o_err;
  logic [NUM_LEDS-1:0]     o_led;
  state_e                  o_dbg_state;

  always #5 sysclk = ~sysclk;

  led_pwm_ctrl #(.NUM_LEDS(NUM_LEDS), .PRESCALE(PRESCALE)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .i_frame_dv  (i_frame_dv),
    .i_cmd       (i_cmd),
    .i_addr      (i_addr),
    .i_payload   (i_payload),
    .i_rd_ack    (i_rd_ack),
    .o_rd_valid  (o_rd_valid),
    .o_rd_data   (o_rd_data),
    .o_err       (o_err),
    .o_led       (o_led),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- model and scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int model_duty [NUM_LEDS];
  // bit 7 = error event, bits 6:0 = read data
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int sat(input int p);
    return (p > PWM_STEPS) ? PWM_STEPS : p;
  endfunction

  // Monitor: every error pulse and every new read response must match the
  // oldest expected event.
  logic       prev_valid = 1'b0;
  logic [7:0] mon_e;
  always @(negedge sysclk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (o_err) begin
        if (exp_q.size() == 0) check("unexpected_err", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("err_event", {24'd0, 1'b1, 7'd0}, {24'd0, mon_e});
        end
      end
      if (o_rd_valid && !prev_valid) begin
        if (exp_q.size() == 0) check("unexpected_rd", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("rd_event", {24'd0, 1'b0, o_rd_data}, {24'd0, mon_e});
        end
      end
      prev_valid = o_rd_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input logic [1:0] cmd, input logic [1:0] addr,
                            input logic [6:0] payload, input int hold);
    bit ok;
    ok = (int'(addr) < NUM_LEDS);
    if (cmd == CMD_WRITE && ok)      model_duty[addr] = sat(int'(payload));
    else if (cmd == CMD_READ && ok)  exp_q.push_back({1'b0, 7'(model_duty[addr])});
    else if (cmd != CMD_NOP)         exp_q.push_back(8'h80);
    @(posedge sysclk); #1;
    i_cmd = cmd; i_addr = addr; i_payload = payload; i_frame_dv = 1'b1;
    repeat (hold) @(posedge sysclk);
    #1 i_frame_dv = 1'b0;
    repeat (3) @(posedge sysclk);
  endtask

  task automatic do_read(input logic [1:0] addr, input bit do_ack);
    int  exp_data;
    bit  got;
    int  n;
    exp_data = model_duty[addr];
    send_frame(CMD_READ, addr, 7'($urandom_range(0, 127)), 1);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sysclk);
      if (o_rd_valid) got = 1'b1;
    end
    check("rd_valid_seen", got, 1);
    if (do_ack && got) begin
      n = $urandom_range(0, 4);
      repeat (n) begin
        @(negedge sysclk);
        check("rd_hold_valid", o_rd_valid, 1);
        check("rd_hold_data", o_rd_data, exp_data);
      end
      @(posedge sysclk); #1 i_rd_ack = 1'b1;
      @(posedge sysclk); #1 i_rd_ack = 1'b0;
      @(negedge sysclk);
      check("rd_clear_after_ack", o_rd_valid, 0);
    end
  endtask

  // Let shadows settle for two periods, then count on-cycles over one period.
  task automatic measure_all(input string tag);
    int cnt [NUM_LEDS];
    repeat (2 * PERIOD) @(negedge sysclk);
    for (int i = 0; i < NUM_LEDS; i++) cnt[i] = 0;
    repeat (PERIOD) begin
      @(negedge sysclk);
      for (int i = 0; i < NUM_LEDS; i++) if (o_led[i]) cnt[i]++;
    end
    for (int i = 0; i < NUM_LEDS; i++)
      check($sformatf("%s_led%0d_ontime", tag, i), cnt[i], model_duty[i] * PRESCALE);
  endtask

  // Watch one LED for a window and count its edges.
  task automatic watch_edges(input int idx, input int cycles,
                             output int rises, output int falls, output int first_rise);
    logic prev;
    rises = 0; falls = 0; first_rise = -1;
    @(negedge sysclk);
    prev = o_led[idx];
    for (int c = 0; c < cycles; c++) begin
      @(negedge sysclk);
      if (o_led[idx] && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      if (!o_led[idx] && prev) falls++;
      prev = o_led[idx];
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   any_active;
    int   extra;
    int   r, f, fr;
    logic [1:0] c, a;
    logic [6:0] p;

    for (int i = 0; i < NUM_LEDS; i++) model_duty[i] = 0;

    // 1: reset values, then idle with no frames
    repeat (3) @(negedge sysclk);
    check("rst_led", o_led, 0);
    check("rst_rd_valid", o_rd_valid, 0);
    check("rst_err", o_err, 0);
    check("rst_rd_data", o_rd_data, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    @(posedge sysclk); #1 rst_n = 1'b1;
    any_active = 0;
    repeat (300) begin
      @(negedge sysclk);
      if (o_led != 0 || o_rd_valid || o_err) any_active++;
    end
    check("idle_outputs_zero", any_active, 0);

    // ack with nothing pending is ignored
    @(posedge sysclk); #1 i_rd_ack = 1'b1;
    @(posedge sysclk); #1 i_rd_ack = 1'b0;
    @(negedge sysclk);
    check("stray_ack_state", o_dbg_state, ST_IDLE);

    // 2: single write
    send_frame(CMD_WRITE, 2'd1, 7'd25, 1);
    measure_all("w25");

    // 3: saturating write and read-back
    send_frame(CMD_WRITE, 2'd2, 7'd127, 2);
    do_read(2'd2, 1'b1);

    // 4: long-held write executes once; long-held read responds once
    send_frame(CMD_WRITE, 2'd0, 7'd60, 50);
    exp_q.push_back({1'b0, 7'(model_duty[2])});
    @(posedge sysclk); #1;
    i_cmd = CMD_READ; i_addr = 2'd2; i_payload = 7'd0; i_frame_dv = 1'b1;
    repeat (5) @(posedge sysclk);
    #1 i_rd_ack = 1'b1;
    @(posedge sysclk); #1 i_rd_ack = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge sysclk);
      if (o_rd_valid) extra++;
    end
    check("held_read_single", extra, 0);
    check("held_read_idle", o_dbg_state, ST_IDLE);
    @(posedge sysclk); #1 i_frame_dv = 1'b0;
    repeat (3) @(posedge sysclk);
    send_frame(CMD_READ, 2'd3, 7'd0, 1);
    check("bad_addr_no_valid", o_rd_valid, 0);
    send_frame(2'b11, 2'd0, 7'd10, 1);
    check("bad_cmd_no_valid", o_rd_valid, 0);
    measure_all("held");

    // 5: glitch-free 0 -> 100 and 100 -> 0 on LED0
    send_frame(CMD_WRITE, 2'd0, 7'd0, 1);
    repeat (2 * PERIOD) @(negedge sysclk);
    repeat ($urandom_range(10, PERIOD - 10)) @(negedge sysclk);
    send_frame(CMD_WRITE, 2'd0, 7'd100, 1);
    watch_edges(0, 2 * PERIOD, r, f, fr);
    check("up_rises", r, 1);
    check("up_falls", f, 0);
    check("up_within_period", (fr >= 0 && fr <= PERIOD + 5), 1);
    check("up_final_high", o_led[0], 1);
    repeat ($urandom_range(10, PERIOD - 10)) @(negedge sysclk);
    send_frame(CMD_WRITE, 2'd0, 7'd0, 1);
    watch_edges(0, 2 * PERIOD, r, f, fr);
    check("down_rises", r, 0);
    check("down_falls", f, 1);
    check("down_final_low", o_led[0], 0);

    // random frames, including unacked reads abandoned by the next frame
    for (int t = 0; t < 40; t++) begin
      c = 2'($urandom_range(0, 3));
      a = 2'($urandom_range(0, 3));
      p = 7'($urandom_range(0, 127));
      if (c == CMD_READ && int'(a) < NUM_LEDS) do_read(a, $urandom_range(0, 3) != 0);
      else send_frame(c, a, p, $urandom_range(1, 4));
    end
    send_frame(CMD_NOP, 2'd0, 7'd0, 1);
    check("nop_clears_pending", o_rd_valid, 0);
    for (int i = 0; i < NUM_LEDS; i++) send_frame(CMD_WRITE, 2'(i), 7'($urandom_range(1, 99)), 1);
    measure_all("rand");

    // 6: asynchronous reset during a pending response
    do_read(2'd1, 1'b0);
    @(posedge sysclk); #3 rst_n = 1'b0;
    #1;
    check("arst_rd_valid", o_rd_valid, 0);
    check("arst_led", o_led, 0);
    check("arst_state", o_dbg_state, ST_IDLE);
    for (int i = 0; i < NUM_LEDS; i++) model_duty[i] = 0;
    repeat (3) @(posedge sysclk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) do_read(2'(i), 1'b1);
    measure_all("post_rst");

    repeat (5) @(negedge sysclk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
